// File: rtl/fixed_mul_seq.sv
// rtl/fixed_mul_seq.sv - sequential shift-add signed fixed-point multiplier (FIXED_MUL_SAT_EN enables saturation)
module fixed_mul_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2*WIDTH-1:0] NEG_LIMIT = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] POS_LIMIT = NEG_LIMIT - 1'b1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic                 sign;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;
  logic                 last;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   mag_m;
  logic [WIDTH-1:0]     neg_m, final_val, res_next;
  logic                 ovf;

  // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude
  assign abs_a = a[WIDTH-1] ? (~a) + WIDTH'(1) : a;
  assign abs_b = b[WIDTH-1] ? (~b) + WIDTH'(1) : b;

  assign mag_m     = acc >> FRAC;
  assign neg_m     = (~mag_m[WIDTH-1:0]) + WIDTH'(1);
  assign final_val = sign ? neg_m : mag_m[WIDTH-1:0];
  assign ovf       = sign ? (mag_m > NEG_LIMIT) : (mag_m > POS_LIMIT);

`ifdef FIXED_MUL_SAT_EN
  assign res_next = !ovf ? final_val :
                    sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_next = final_val;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // CALC spends WIDTH cycles on shift-add and one more cycle registering the result
  always_ff @(posedge clk) begin
    if (rst) begin
      sign     <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      count    <= '0;
      last     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= a[WIDTH-1] ^ b[WIDTH-1];
            mag_a <= abs_a;
            mag_b <= abs_b;
            acc   <= '0;
            count <= '0;
            last  <= 1'b0;
          end
        end
        CALC: begin
          if (!last) begin
            if (mag_b[count]) acc <= acc + ({{WIDTH{1'b0}}, mag_a} << count);
            if (count == CW'(WIDTH-1)) last <= 1'b1;
            else                       count <= count + CW'(1);
          end else begin
            result   <= res_next;
            overflow <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_mul_seq.sv
// tb/tb_fixed_mul_seq.sv - scoreboard bench for fixed_mul_seq against an arithmetic reference model
`timescale 1ns/1ps
module tb_fixed_mul_seq;
  localparam int W = 32;
  localparam int F = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  typedef struct packed {
    logic [W-1:0] r;
    logic         o;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fixed_mul_seq #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Exact product scaled by 2^-F, truncated toward zero, then range-checked
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint     sx, sy, v;
    logic [63:0] mx, my, m;
    logic       neg;
    exp_t       e;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    neg = (sx < 0) != (sy < 0);
    mx  = (sx < 0) ? -sx : sx;
    my  = (sy < 0) ? -sy : sy;
    m   = (mx * my) >> F;
    v   = neg ? -longint'(m) : longint'(m);
    e.o = neg ? (m > (64'd1 << (W-1))) : (m > ((64'd1 << (W-1)) - 1));
    e.r = v[W-1:0];
`ifdef FIXED_MUL_SAT_EN
    if (e.o) e.r = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result 0x%0h with no pending product", result);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.r);
        check("overflow", overflow, e.o);
      end
    end
  end

  // Advance one cycle; returns at the falling edge, where inputs change and outputs are sampled
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    a = x;
    b = y;
    tick();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin
        v = $urandom_range(0, 32'h0003FFFF);
        if ($urandom_range(0, 1) == 1) v = 32'h0 - v;
      end
      2: begin
        case ($urandom_range(0, 3))
          0: v = 32'h80000000;
          1: v = 32'h7FFFFFFF;
          2: v = 32'h0;
          default: v = 32'hFFFFFFFF;
        endcase
      end
      default: v = $urandom_range(0, 32'h00FFFFFF);
    endcase
    return v;
  endfunction

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic         o;
  } vec_t;

  initial begin
    int   edges;
    int   seen;
    vec_t vecs[$];

    // reset with in_valid held high: nothing may be accepted
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    vecs.push_back('{32'h00018000, 32'h00020000, 32'h00030000, 1'b0});
    vecs.push_back('{32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b0});
    vecs.push_back('{32'hFFFF0000, 32'hFFFF0000, 32'h00010000, 1'b0});
`ifdef FIXED_MUL_SAT_EN
    vecs.push_back('{32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b1});
`else
    vecs.push_back('{32'h7FFF0000, 32'h00020000, 32'hFFFE0000, 1'b1});
`endif
    vecs.push_back('{32'h80000000, 32'h00010000, 32'h80000000, 1'b0});
    vecs.push_back('{32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b0});

    foreach (vecs[i]) begin
      exp_q.push_back('{vecs[i].r, vecs[i].o});
      issue(vecs[i].x, vecs[i].y);
      wait_out(edges);
      check("latency", edges, 33);
    end

    // backpressure: DONE must hold while inputs churn
    tick();
    out_ready = 1'b0;
    exp_q.push_back('{32'h00030000, 1'b0});
    issue(32'h00018000, 32'h00020000);
    wait_out(edges);
    check("bp_latency", edges, 33);
    for (int i = 0; i < 5; i++) begin
      in_valid = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 32'h00030000);
      check("bp_overflow", overflow, 0);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    check("release_no_accept", in_ready, 1);

    // reset in the middle of CALC discards the product
    issue(32'h7FFF0000, 32'h7FFF0000);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    exp_q.push_back('{32'h00010000, 1'b0});
    issue(32'h00010000, 32'h00010000);
    wait_out(edges);
    check("midrst_new_latency", edges, 33);

    // randomized traffic with random downstream stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      logic [W-1:0] x, y;
      x = pick_operand();
      y = pick_operand();
      exp_q.push_back(model(x, y));
      issue(x, y);
    end
    edges = 0;
    while (exp_q.size() != 0 && edges < 2000) begin
      tick();
      edges++;
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    check("queue_drained", exp_q.size(), 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
